pc_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the byte-addressed instruction ROM.
- Owns the program counter and drives the ROM address.
- Captures the returned 32-bit big-endian word into a fetch output register with a valid/ready handshake toward decode.
- Accepts redirects (branch/jump) and a halt request from later stages.

---
 rtl/pc_fetch_unit.sv | 131 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the program counter, addresses the instruction
// ROM and registers the returned word toward decode with a valid/ready handshake.
// Redirects reload the PC and drop the held word; a halt request parks the
// stage until the next redirect.
module pc_fetch_unit #(
  parameter int unsigned                ADDRESS_WIDTH = 8,
  parameter int unsigned                DATAOUT_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] A,
  input  logic [DATAOUT_WIDTH-1:0] RD,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  input  logic                     halt_req,
  output logic [DATAOUT_WIDTH-1:0] instr_out,
  output logic [ADDRESS_WIDTH-1:0] pc_out,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic                     halted,
  output logic [15:0]              fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e                   state_q, state_d;

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [DATAOUT_WIDTH-1:0] instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] pcOut_q, pcOut_d;
  logic [ADDRESS_WIDTH-1:0] pcPlus4_q, pcPlus4_d;
  logic                     valid_q, valid_d;
  logic [15:0]              count_q, count_d;

  logic                     fetchEn;
  logic                     acceptEn;
  logic [ADDRESS_WIDTH-1:0] redirectAligned;
  logic [ADDRESS_WIDTH-1:0] pcNext;

  // Redirect targets are word aligned by clearing the two low address bits.
  assign redirectAligned = redirect_target & ~ADDRESS_WIDTH'(3);
  assign pcNext          = pc_q + ADDRESS_WIDTH'(4);

  // ROM address comes straight from the PC register, so no input reaches A combinationally.
  assign A            = pc_q;
  assign instr_out    = instr_q;
  assign pc_out       = pcOut_q;
  assign pc_plus4_out = pcPlus4_q;
  assign valid_out    = valid_q;
  assign fetch_count  = count_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: BOOT lasts one cycle, redirect beats halt_req and revives HALT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (!redirect && halt_req) state_d = HALT;
      HALT:    if (redirect) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // FSM outputs: fetch when running and the output slot is empty or being drained.
  always_comb begin
    fetchEn  = (state_q == RUN) && (!valid_q || ready_in) && !redirect;
    acceptEn = valid_q && ready_in;
    halted   = (state_q == HALT);
  end

  // Datapath next state: redirect, then fetch, then drain; count every accepted word.
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    pcOut_d   = pcOut_q;
    pcPlus4_d = pcPlus4_q;
    valid_d   = valid_q;
    count_d   = count_q;

    if (redirect) begin
      pc_d    = redirectAligned;
      valid_d = 1'b0;
    end else if (fetchEn) begin
      instr_d   = RD;
      pcOut_d   = pc_q;
      pcPlus4_d = pcNext;
      valid_d   = 1'b1;
      pc_d      = pcNext;
    end else if (acceptEn) begin
      valid_d = 1'b0;
    end

    if (acceptEn && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      pcOut_q   <= '0;
      pcPlus4_q <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pcOut_q   <= pcOut_d;
      pcPlus4_q <= pcPlus4_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a cycle-level behavioural model is
// compared against the DUT on every falling edge, and directed scenarios pin
// hand-computed values.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  A;
  logic [31:0] RD;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_target = 8'h00;
  logic        halt_req = 1'b0;
  logic [31:0] instr_out;
  logic [7:0]  pc_out;
  logic [7:0]  pc_plus4_out;
  logic        valid_out;
  logic        ready_in = 1'b1;
  logic        halted;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [64];

  // Model state.
  logic [7:0]  mPc;
  logic [31:0] mInstr;
  logic [7:0]  mPcOut;
  logic [7:0]  mPlus4;
  logic        mValid;
  logic        mBooting;
  logic        mHalted;
  logic [15:0] mCount;
  logic        modelLive = 1'b0;

  logic [7:0]  frozenA;
  logic [15:0] frozenCount;

  pc_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .A               (A),
    .RD              (RD),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .pc_plus4_out    (pc_plus4_out),
    .valid_out       (valid_out),
    .ready_in        (ready_in),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  assign RD = rom[A[7:2]];

  function automatic logic [31:0] romWord(input logic [7:0] addr);
    return rom[addr[7:2]];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic rdy, input logic redir,
                               input logic [7:0] target, input logic halt);
    rst_n           = rstN;
    ready_in        = rdy;
    redirect        = redir;
    redirect_target = target;
    halt_req        = halt;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: one step per rising edge from the inputs seen at that edge.
  always @(posedge clk) begin
    logic running;
    logic takes;
    logic fetches;
    if (!rst_n) begin
      mPc = 8'h00; mInstr = '0; mPcOut = '0; mPlus4 = '0;
      mValid = 1'b0; mBooting = 1'b1; mHalted = 1'b0; mCount = '0;
      modelLive = 1'b1;
    end else if (modelLive) begin
      running = !mBooting && !mHalted;
      takes   = mValid && ready_in;
      fetches = running && (!mValid || ready_in) && !redirect;
      if (takes && mCount != 16'hFFFF) mCount = mCount + 16'd1;
      if (redirect) begin
        mPc      = {redirect_target[7:2], 2'b00};
        mValid   = 1'b0;
        mBooting = 1'b0;
        mHalted  = 1'b0;
      end else begin
        if (fetches) begin
          mInstr = romWord(mPc);
          mPcOut = mPc;
          mPlus4 = mPc + 8'd4;
          mValid = 1'b1;
          mPc    = mPc + 8'd4;
        end else if (takes) begin
          mValid = 1'b0;
        end
        if (mBooting) mBooting = 1'b0;
        else if (halt_req) mHalted = 1'b1;
      end
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("model_A", {24'h0, A}, {24'h0, mPc});
      checkOutput("model_valid", {31'h0, valid_out}, {31'h0, mValid});
      checkOutput("model_halted", {31'h0, halted}, {31'h0, mHalted});
      checkOutput("model_count", {16'h0, fetch_count}, {16'h0, mCount});
      if (mValid) begin
        checkOutput("model_instr", instr_out, mInstr);
        checkOutput("model_pc_out", {24'h0, pc_out}, {24'h0, mPcOut});
        checkOutput("model_pc_plus4", {24'h0, pc_plus4_out}, {24'h0, mPlus4});
      end
    end
  end

  // Directed scenarios with literal expectations.
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = {8'hA5, 8'(i), 8'h5A, 8'(i ^ 8'hFF)};
    rom[0] = 32'h11111111;
    rom[1] = 32'h22222222;

    // Reset.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(2);
    checkOutput("rst_valid", {31'h0, valid_out}, 32'h0);
    checkOutput("rst_count", {16'h0, fetch_count}, 32'h0);
    checkOutput("rst_halted", {31'h0, halted}, 32'h0);
    checkOutput("rst_A", {24'h0, A}, 32'h0);
    checkOutput("rst_instr", instr_out, 32'h0);
    checkOutput("rst_pc_out", {24'h0, pc_out}, 32'h0);
    checkOutput("rst_plus4", {24'h0, pc_plus4_out}, 32'h0);

    // Free run.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(1);
    checkOutput("boot_A", {24'h0, A}, 32'h00);
    checkOutput("boot_valid", {31'h0, valid_out}, 32'h0);
    tick(1);
    checkOutput("run0_instr", instr_out, 32'h11111111);
    checkOutput("run0_pc", {24'h0, pc_out}, 32'h00);
    checkOutput("run0_plus4", {24'h0, pc_plus4_out}, 32'h04);
    tick(1);
    checkOutput("run1_instr", instr_out, 32'h22222222);
    checkOutput("run1_pc", {24'h0, pc_out}, 32'h04);
    checkOutput("run1_count", {16'h0, fetch_count}, 32'd1);
    tick(1);
    checkOutput("run2_pc", {24'h0, pc_out}, 32'h08);
    checkOutput("run2_count", {16'h0, fetch_count}, 32'd2);

    // Backpressure for three cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick(3);
    checkOutput("stall_pc", {24'h0, pc_out}, 32'h08);
    checkOutput("stall_A", {24'h0, A}, 32'h0C);
    checkOutput("stall_count", {16'h0, fetch_count}, 32'd2);
    checkOutput("stall_valid", {31'h0, valid_out}, 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(1);
    checkOutput("release_pc", {24'h0, pc_out}, 32'h0C);
    checkOutput("release_count", {16'h0, fetch_count}, 32'd3);

    // Redirect with an unaligned target while a word is held.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h43, 1'b0);
    tick(1);
    checkOutput("redir_valid", {31'h0, valid_out}, 32'h0);
    checkOutput("redir_A", {24'h0, A}, 32'h40);
    checkOutput("redir_count", {16'h0, fetch_count}, 32'd4);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(1);
    checkOutput("redir_pc", {24'h0, pc_out}, 32'h40);
    checkOutput("redir_instr", instr_out, 32'hA5105AEF);

    // Wrap-around.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hF8, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(1);
    checkOutput("wrap_pc_f8", {24'h0, pc_out}, 32'hF8);
    tick(1);
    checkOutput("wrap_pc_fc", {24'h0, pc_out}, 32'hFC);
    checkOutput("wrap_plus4_fc", {24'h0, pc_plus4_out}, 32'h00);
    tick(1);
    checkOutput("wrap_pc_00", {24'h0, pc_out}, 32'h00);
    checkOutput("wrap_instr_00", instr_out, 32'h11111111);

    // Halt at PC=0x10.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h10, 1'b0);
    tick(1);
    checkOutput("halt_pre_A", {24'h0, A}, 32'h10);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("halt_halted", {31'h0, halted}, 32'h1);
    checkOutput("halt_pc", {24'h0, pc_out}, 32'h10);
    checkOutput("halt_valid", {31'h0, valid_out}, 32'h1);
    checkOutput("halt_A", {24'h0, A}, 32'h14);
    tick(1);
    checkOutput("halt_drained", {31'h0, valid_out}, 32'h0);
    frozenA = A;
    frozenCount = fetch_count;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    tick(3);
    checkOutput("halt_A_frozen", {24'h0, A}, {24'h0, frozenA});
    checkOutput("halt_A_value", {24'h0, A}, 32'h14);
    checkOutput("halt_count_frozen", {16'h0, fetch_count}, {16'h0, frozenCount});
    checkOutput("halt_still", {31'h0, halted}, 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h20, 1'b0);
    tick(1);
    checkOutput("resume_halted", {31'h0, halted}, 32'h0);
    checkOutput("resume_A", {24'h0, A}, 32'h20);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(1);
    checkOutput("resume_pc", {24'h0, pc_out}, 32'h20);

    // Simultaneous halt_req and redirect: redirect wins.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h80, 1'b1);
    tick(1);
    checkOutput("both_halted", {31'h0, halted}, 32'h0);
    checkOutput("both_A", {24'h0, A}, 32'h80);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(1);
    checkOutput("both_pc", {24'h0, pc_out}, 32'h80);

    // Reset mid-stall at PC=0x30.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h2C, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick(2);
    checkOutput("ms_A", {24'h0, A}, 32'h30);
    checkOutput("ms_valid", {31'h0, valid_out}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick(1);
    checkOutput("ms_rst_valid", {31'h0, valid_out}, 32'h0);
    checkOutput("ms_rst_A", {24'h0, A}, 32'h00);
    checkOutput("ms_rst_count", {16'h0, fetch_count}, 32'h0);
    checkOutput("ms_rst_halted", {31'h0, halted}, 32'h0);

    // halt_req during BOOT is ignored.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("bootHalt_valid", {31'h0, valid_out}, 32'h0);
    checkOutput("bootHalt_halted", {31'h0, halted}, 32'h0);
    tick(1);
    checkOutput("bootHalt_fetch", {31'h0, valid_out}, 32'h1);
    checkOutput("bootHalt_pc", {24'h0, pc_out}, 32'h00);

    // Counter saturation.
    tick(65540);
    checkOutput("sat_count", {16'h0, fetch_count}, 32'h0000FFFF);
    tick(2);
    checkOutput("sat_hold", {16'h0, fetch_count}, 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
